fifo_flex: RTL and testbench
============================

// Module: fifo_flex
// PURPOSE
//  Parametrised synchronous FIFO, the successor to the single-mode FIFO.
//  - Adds an occupancy count, programmable almost_full/almost_empty thresholds,
//    sticky overflow/underflow error flags, a synchronous flush, and a first-word-fall-through (FWFT) mode.
//  - Sits between any single-clock producer/consumer pair in the datapath.
// PARAMETERS
//  WIDTH      8    data width in bits (>=1)
//  DEPTH      16   entries; power of two, >=4
//  FWFT       0    0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through
//  AF_THRESH  12   almost_full asserted when count >= AF_THRESH (1..DEPTH-1)
//  AE_THRESH  2    almost_empty asserted when count <= AE_THRESH (0..AF_THRESH-1)
//  PT_WIDTH   $clog2(DEPTH)   derived; do not override
// PORTS
//  clock         in   1            single clock, rising edge
//  resetn        in   1            asynchronous, active-low reset
//  clear         in   1            synchronous flush, active high
//  write_enb     in   1            write request
//  data_in       in   WIDTH        write data
//  read_enb      in   1            read request (FWFT: pop/acknowledge)
//  data_out      out  WIDTH        read data
//  data_valid    out  1            std: 1-cycle pulse, data_out updated; FWFT: = ~empty
//  full          out  1            count == DEPTH
//  empty         out  1            count == 0
//  almost_full   out  1            count >= AF_THRESH
//  almost_empty  out  1            count <= AE_THRESH
//  count         out  PT_WIDTH+1   current occupancy, 0..DEPTH
//  overflow      out  1            sticky: write dropped
//  underflow     out  1            sticky: read refused
// BEHAVIOUR
//  Reset (async, resetn=0):
//   - wr_ptr, rd_ptr, count = 0; empty = 1, almost_empty = 1; all other flags 0; data_out = 0, data_valid = 0.
//   - Memory contents are not reset.
//  Acceptance (flags sampled at start of cycle):
//   - rd_acc = read_enb & ~empty
//   - wr_acc = write_enb & (~full | rd_acc); a write while full plus a read is accepted
//   - Read while empty plus a write: the read is refused, the write is accepted.
//  Pointers: PT_WIDTH bits, +1 on acceptance, wrap DEPTH-1 -> 0 naturally.
//  Count: count <= count + wr_acc - rd_acc, held in PT_WIDTH+1 bits.
//   - All flags decode combinationally from registered count.
//   - Simultaneous accepted read and write leave count unchanged.
//  Standard mode (FWFT=0):
//   - On rd_acc, data_out <= mem[rd_ptr] at that edge; data_valid = 1 for exactly that following cycle.
//   - Otherwise data_out holds its last value; it is never driven to z.
//  FWFT mode (FWFT=1):
//   - data_out = mem[rd_ptr] whenever ~empty; data_valid = ~empty.
//   - read_enb pops the displayed word.
//   - A word written into an empty FIFO appears on data_out the cycle after the write.
//  Errors:
//   - overflow  <= 1 when write_enb & ~wr_acc
//   - underflow <= 1 when read_enb & empty
//   - Both hold until clear or reset.
//  clear:
//   - Pointers, count, overflow, underflow <= 0; data_valid <= 0; data_out holds its value.
//   - clear beats a same-cycle read/write; both requests are ignored and are not flagged as errors.
//  Reset mid-operation: all state returns to the reset values immediately, without waiting for a clock edge.
//  Illegal parameters (non-power-of-two DEPTH, bad thresholds): $error at elaboration.
// STRUCTURE
//  fifo_pkg:
//   - localparams FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
//   - Threshold legality check function, shared with future async/multi-channel variants.
//  Sub-module fifo_mem_dp:
//   - Parameters WIDTH, DEPTH, ASYNC_RD.
//   - One write port, one read port; ASYNC_RD = 1 for FWFT, 0 = registered read.
//   - Holds no control logic.
//  Top level: pointer/count/flag/error logic plus the data_valid generation.
// TESTING  (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1 unless noted)
//  1. Write 0x01..0x08, then 1 more write
//     -> full=1, count=8, almost_full set at count=6
//     -> 9th write dropped, overflow=1; reads return 0x01..0x08 in order.
//  2. Write 0x10..0x17 (full), then write 0xAA + read in the same cycle
//     -> read returns 0x10, count stays 8, 0xAA is the 8th word out.
//  3. 20 writes interleaved with reads, forcing pointer wrap twice
//     -> output order is preserved, count never exceeds 8, no error flags.
//  4. FWFT=1: write 0x5A into empty FIFO
//     -> data_out=0x5A, data_valid=1 the next cycle
//     -> read_enb -> empty=1, data_valid=0.
//  5. Read on empty FIFO
//     -> underflow=1, data_out unchanged, data_valid=0
//     -> clear -> underflow=0, count=0.
//  6. Assert resetn=0 mid-burst at count=5, off clock edge
//     -> count=0, empty=1, data_valid=0 with no clock edge required.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings and the
// parameter legality helpers used at elaboration time.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Thresholds must leave a gap: 0 <= ae < af < depth.
  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth - 1) && (ae >= 0) && (ae <= af - 1);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_dp.sv
// Simple dual-port storage: one write port, one read port. The read port is
// either combinational (ASYNC_RD=1, used for first-word-fall-through) or
// registered with a read enable (ASYNC_RD=0). No flow-control logic here.
module fifo_mem_dp #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ASYNC_RD = 0,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: the storage array is deliberately left without a reset so it maps
  // onto RAM; only control state and the output register are reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  if (ASYNC_RD != 0) begin : g_async_rd
    // Combinational read: the addressed word is visible in the same cycle.
    assign rd_data = mem[rd_addr];

    // Enable and reset only matter for the registered read port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = ^{resetn, rd_en};
  end else begin : g_sync_rd
    // Registered read: capture the addressed word on rd_en, hold otherwise.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; a read and write to the same address at one edge
    // therefore returns the old word.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)    rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
    end
  end

endmodule : fifo_mem_dp

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and an optional first-word-fall-through read mode.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = FIFO_MODE_STD,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int PT_WIDTH  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              write_enb,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              read_enb,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PT_WIDTH:0] count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = PT_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

  // Elaboration-time parameter checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_flex: WIDTH must be >= 1 (got %0d)", WIDTH);
  end
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be a power of two >= 4 (got %0d)", DEPTH);
  end
  if (PT_WIDTH != $clog2(DEPTH)) begin : g_bad_ptw
    $error("fifo_flex: PT_WIDTH is derived from DEPTH and must not be overridden");
  end
  if (!thresholds_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("fifo_flex: need 0 <= AE_THRESH < AF_THRESH < DEPTH (AF=%0d AE=%0d)",
           AF_THRESH, AE_THRESH);
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_flex: FWFT must be 0 or 1 (got %0d)", FWFT);
  end

  logic [PT_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                rd_acc, wr_acc;   // accepted requests, before flush
  logic                rd_do, wr_do;     // requests that actually change state
  logic [WIDTH-1:0]    mem_rd_data;

  // Status flags decoded from the registered occupancy.
  // NOTE: every output of this block is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    count        = count_q;
    full         = (count_q == FULL_CNT);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
  end

  // Request acceptance: a read frees a slot for a same-cycle write when full;
  // a flush overrides both requests.
  always_comb begin
    rd_acc = read_enb & ~empty;
    wr_acc = write_enb & (~full | rd_acc);
    rd_do  = rd_acc & ~clear;
    wr_do  = wr_acc & ~clear;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_do) wr_ptr <= wr_ptr + PT_WIDTH'(1);
      if (rd_do) rd_ptr <= rd_ptr + PT_WIDTH'(1);
      case ({wr_do, rd_do})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a flush clears them and its own requests never set them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enb & ~wr_acc) overflow  <= 1'b1;
      if (read_enb & empty)    underflow <= 1'b1;
    end
  end

  fifo_mem_dp #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ASYNC_RD ((FWFT == FIFO_MODE_FWFT) ? 1 : 0),
    .ADDR_W   (PT_WIDTH)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_do),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_do),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly; zero while nothing is stored.
    always_comb begin
      data_out   = empty ? '0 : mem_rd_data;
      data_valid = ~empty;
    end
  end else begin : g_std
    logic dv_q;

    // One-cycle valid pulse following each accepted read.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) dv_q <= 1'b0;
      else         dv_q <= rd_do;
    end

    // Registered read data held by the memory read port.
    always_comb begin
      data_out   = mem_rd_data;
      data_valid = dv_q;
    end
  end

endmodule : fifo_flex

// File: tb/tb_fifo_flex.sv
// Directed bench for fifo_flex: a standard-mode and a FWFT instance
// (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1) sharing clock and reset.
module tb_fifo_flex;

  logic       clock, resetn;
  logic       clear, write_enb, read_enb;
  logic [7:0] data_in, data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  logic       fw_clear, fw_write_enb, fw_read_enb;
  logic [7:0] fw_data_in, fw_data_out;
  logic       fw_data_valid, fw_full, fw_empty, fw_almost_full, fw_almost_empty;
  logic [3:0] fw_count;
  logic       fw_overflow, fw_underflow;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_last;

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut (
    .clock(clock), .resetn(resetn), .clear(clear),
    .write_enb(write_enb), .data_in(data_in), .read_enb(read_enb),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_flex #(.WIDTH(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) dut_fw (
    .clock(clock), .resetn(resetn), .clear(fw_clear),
    .write_enb(fw_write_enb), .data_in(fw_data_in), .read_enb(fw_read_enb),
    .data_out(fw_data_out), .data_valid(fw_data_valid), .full(fw_full), .empty(fw_empty),
    .almost_full(fw_almost_full), .almost_empty(fw_almost_empty), .count(fw_count),
    .overflow(fw_overflow), .underflow(fw_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock of stimulus on the standard instance; outputs settle by return.
  task automatic cycle(input logic wr, input logic [7:0] din, input logic rd, input logic clr);
    write_enb = wr; data_in = din; read_enb = rd; clear = clr;
    @(posedge clock); #1;
    write_enb = 1'b0; read_enb = 1'b0; clear = 1'b0;
  endtask

  task automatic fw_cycle(input logic wr, input logic [7:0] din, input logic rd);
    fw_write_enb = wr; fw_data_in = din; fw_read_enb = rd;
    @(posedge clock); #1;
    fw_write_enb = 1'b0; fw_read_enb = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] flags;
    resetn = 1'b0;
    #12;
    flags = {full, empty, almost_full, almost_empty, overflow, underflow, data_valid};
    checks++;
    if (flags !== 7'b0101000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0101000", flags);
    end
    checks++;
    if (count !== 4'd0 || data_out !== 8'h00) begin
      errors++; $display("FAIL reset_count_data: got count=%0d data=%h expected 0/00", count, data_out);
    end
    flags = {fw_full, fw_empty, fw_almost_full, fw_almost_empty, fw_overflow, fw_underflow, fw_data_valid};
    checks++;
    if (flags !== 7'b0101000 || fw_count !== 4'd0 || fw_data_out !== 8'h00) begin
      errors++; $display("FAIL reset_fwft: got flags=%b count=%0d data=%h expected 0101000/0/00",
                         flags, fw_count, fw_data_out);
    end
    #1 resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_fill_overflow();
    logic exp_af, exp_ae;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      exp_af = (i >= 6);
      exp_ae = (i <= 1);
      checks++;
      if (count !== 4'(i) || almost_full !== exp_af || almost_empty !== exp_ae) begin
        errors++; $display("FAIL fill_%0d: got count=%0d af=%b ae=%b expected %0d/%b/%b",
                           i, count, almost_full, almost_empty, i, exp_af, exp_ae);
      end
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_flag: got full=%b ovf=%b expected 1/0", full, overflow);
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow: got count=%0d ovf=%b expected 8/1", count, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== 8'(i) || data_valid !== 1'b1 || count !== 4'(8 - i)) begin
        errors++; $display("FAIL drain_%0d: got data=%h dv=%b count=%0d expected %h/1/%0d",
                           i, data_out, data_valid, count, 8'(i), 8 - i);
      end
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || empty !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL after_drain: got dv=%b empty=%b ovf=%b expected 0/1/1",
                         data_valid, empty, overflow);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clear_ovf: got ovf=%b expected 0", overflow);
    end
  endtask

  task automatic test_full_rw();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL full_rw_pre: got full=%b expected 1", full);
    end
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if (data_out !== 8'h10 || count !== 4'd8 || overflow !== 1'b0 || data_valid !== 1'b1) begin
      errors++; $display("FAIL full_rw: got data=%h count=%0d ovf=%b dv=%b expected 10/8/0/1",
                         data_out, count, overflow, data_valid);
    end
    for (int i = 1; i <= 8; i++) begin
      exp = (i == 8) ? 8'hAA : 8'h10 + 8'(i);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (data_out !== exp) begin
        errors++; $display("FAIL full_rw_read_%0d: got %h expected %h", i, data_out, exp);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL full_rw_empty: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp;
    logic       rd, expect_read;
    for (int i = 0; i < 23; i++) begin
      logic wr;
      wr = (i < 20);
      rd = (i >= 3);
      expect_read = rd && (q.size() > 0);
      exp = 8'h00;
      if (expect_read) exp = q.pop_front();
      if (wr) q.push_back(8'h30 + 8'(i));
      cycle(wr, 8'h30 + 8'(i), rd, 1'b0);
      checks++;
      if (count !== 4'(q.size()) || (expect_read && (data_out !== exp || data_valid !== 1'b1))) begin
        errors++; $display("FAIL wrap_%0d: got count=%0d data=%h dv=%b expected %0d/%h/%b",
                           i, count, data_out, data_valid, q.size(), exp, expect_read);
      end
      if (expect_read) exp_last = exp;
    end
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL wrap_flags: got ovf=%b unf=%b empty=%b expected 0/0/1",
                         overflow, underflow, empty);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || data_out !== exp_last || data_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL underflow: got unf=%b data=%h dv=%b count=%0d expected 1/%h/0/0",
                         underflow, data_out, data_valid, count, exp_last);
    end
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd1 || data_valid !== 1'b0 || data_out !== exp_last) begin
      errors++; $display("FAIL empty_rw: got count=%0d dv=%b data=%h expected 1/0/%h",
                         count, data_valid, data_out, exp_last);
    end
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0 || count !== 4'd0 ||
        data_valid !== 1'b0 || data_out !== exp_last) begin
      errors++; $display("FAIL clear: got unf=%b ovf=%b count=%0d dv=%b data=%h expected 0/0/0/0/%h",
                         underflow, overflow, count, data_valid, data_out, exp_last);
    end
  endtask

  task automatic test_fwft();
    fw_cycle(1'b1, 8'h5A, 1'b0);
    checks++;
    if (fw_data_out !== 8'h5A || fw_data_valid !== 1'b1 || fw_count !== 4'd1) begin
      errors++; $display("FAIL fwft_show: got data=%h dv=%b count=%0d expected 5a/1/1",
                         fw_data_out, fw_data_valid, fw_count);
    end
    fw_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (fw_empty !== 1'b1 || fw_data_valid !== 1'b0) begin
      errors++; $display("FAIL fwft_pop: got empty=%b dv=%b expected 1/0", fw_empty, fw_data_valid);
    end
    fw_cycle(1'b1, 8'h11, 1'b0);
    fw_cycle(1'b1, 8'h22, 1'b0);
    checks++;
    if (fw_data_out !== 8'h11 || fw_count !== 4'd2) begin
      errors++; $display("FAIL fwft_head: got data=%h count=%0d expected 11/2", fw_data_out, fw_count);
    end
    fw_cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (fw_data_out !== 8'h22 || fw_data_valid !== 1'b1) begin
      errors++; $display("FAIL fwft_next: got data=%h dv=%b expected 22/1", fw_data_out, fw_data_valid);
    end
    fw_cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd5 || data_valid !== 1'b1 || data_out !== 8'h61) begin
      errors++; $display("FAIL pre_reset: got count=%0d dv=%b data=%h expected 5/1/61",
                         count, data_valid, data_out);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || data_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL async_reset: got count=%0d empty=%b dv=%b data=%h expected 0/1/0/00",
                         count, empty, data_valid, data_out);
    end
    #2 resetn = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL post_reset: got count=%0d empty=%b expected 0/1", count, empty);
    end
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; write_enb = 1'b0; read_enb = 1'b0; data_in = 8'h00;
    fw_clear = 1'b0; fw_write_enb = 1'b0; fw_read_enb = 1'b0; fw_data_in = 8'h00;
    exp_last = 8'h00;
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_wrap();
    test_underflow();
    test_fwft();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_flex
